// File: rtl/traffic_phase_sched.sv
// Actuated NS/ES intersection phase scheduler with pedestrian walk phase.
// All timing advances on the external tick strobe; lamps are Moore-decoded from state.
module traffic_phase_sched #(
  parameter int GREEN_MIN = 10,
  parameter int GREEN_MAX = 30,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 8,
  parameter int CNT_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ns_req,
  input  logic       es_req,
  input  logic       ped_req,
  output logic [1:0] ns_light,
  output logic [1:0] es_light,
  output logic       ped_walk,
  output logic [2:0] state_o
);

  localparam logic [2:0] S_CLEAR = 3'd0;
  localparam logic [2:0] S_NS_G  = 3'd1;
  localparam logic [2:0] S_NS_Y  = 3'd2;
  localparam logic [2:0] S_ES_G  = 3'd3;
  localparam logic [2:0] S_ES_Y  = 3'd4;
  localparam logic [2:0] S_WALK  = 3'd5;

  localparam logic [1:0] L_RED    = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_GREEN  = 2'b10;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_ES = 1'b1;

  localparam int CW1 = CNT_W + 1;
  localparam logic [CNT_W:0] GMIN_C   = CW1'(GREEN_MIN);
  localparam logic [CNT_W:0] GMAX_C   = CW1'(GREEN_MAX);
  localparam logic [CNT_W:0] YELLOW_C = CW1'(YELLOW_T);
  localparam logic [CNT_W:0] ALLRED_C = CW1'(ALLRED_T);
  localparam logic [CNT_W:0] WALK_C   = CW1'(WALK_T);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;
  logic             next_dir;
  logic             ped_pending;
  logic             own;
  logic             opp;
  logic             dem;
  logic             green_exit;

  // cnt_inc is the number of ticks the phase will have lasted after this tick
  always_comb begin
    cnt_inc    = {1'b0, cnt} + CW1'(1);
    own        = (state == S_ES_G) ? es_req : ns_req;
    opp        = (state == S_ES_G) ? ns_req : es_req;
    dem        = opp | ped_pending;
    green_exit = dem && (((cnt_inc >= GMIN_C) && !own) || (cnt_inc >= GMAX_C));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR: begin
        if (tick && (cnt_inc >= ALLRED_C)) begin
          if (ped_pending)              state_nxt = S_WALK;
          else if (next_dir == DIR_NS)  state_nxt = S_NS_G;
          else                          state_nxt = S_ES_G;
        end
      end
      S_NS_G: if (tick && green_exit)             state_nxt = S_NS_Y;
      S_NS_Y: if (tick && (cnt_inc >= YELLOW_C))  state_nxt = S_CLEAR;
      S_ES_G: if (tick && green_exit)             state_nxt = S_ES_Y;
      S_ES_Y: if (tick && (cnt_inc >= YELLOW_C))  state_nxt = S_CLEAR;
      S_WALK: if (tick && (cnt_inc >= WALK_C))    state_nxt = S_CLEAR;
      default:                                    state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_CLEAR;
      cnt         <= '0;
      next_dir    <= DIR_NS;
      ped_pending <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= '0;
      else if (tick && (cnt_inc <= GMAX_C))
        cnt <= cnt_inc[CNT_W-1:0];

      if ((state == S_NS_Y) && (state_nxt == S_CLEAR))
        next_dir <= DIR_ES;
      else if ((state == S_ES_Y) && (state_nxt == S_CLEAR))
        next_dir <= DIR_NS;

      // entering WALK consumes the request; presses during WALK are dropped
      if ((state_nxt == S_WALK) && (state != S_WALK))
        ped_pending <= 1'b0;
      else if (ped_req && (state != S_WALK))
        ped_pending <= 1'b1;
    end
  end

  always_comb begin
    ns_light = L_RED;
    es_light = L_RED;
    ped_walk = 1'b0;
    case (state)
      S_NS_G:  ns_light = L_GREEN;
      S_NS_Y:  ns_light = L_YELLOW;
      S_ES_G:  es_light = L_GREEN;
      S_ES_Y:  es_light = L_YELLOW;
      S_WALK:  ped_walk = 1'b1;
      default: ped_walk = 1'b0;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Scoreboard bench for traffic_phase_sched: directed per-tick expected states,
// direct checks for reset/idle behaviour, and a lamp-safety monitor every clock.
module tb_traffic_phase_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       ns_req = 1'b0;
  logic       es_req = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] ns_light;
  logic [1:0] es_light;
  logic       ped_walk;
  logic [2:0] state_o;

  int compared = 0;
  int mismatched = 0;
  bit sb_en = 1'b1;
  string tag = "init";
  logic [2:0] exp_q[$];
  logic [2:0] mon_exp;
  logic [4:0] mon_lamps;

  traffic_phase_sched #(
    .GREEN_MIN(2), .GREEN_MAX(4), .YELLOW_T(1), .ALLRED_T(1), .WALK_T(2), .CNT_W(6)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .ns_req(ns_req), .es_req(es_req), .ped_req(ped_req),
    .ns_light(ns_light), .es_light(es_light), .ped_walk(ped_walk), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // expected {ns_light, es_light, ped_walk} for a state code
  function automatic logic [4:0] lamps(input logic [2:0] s);
    case (s)
      3'd1:    return {2'b10, 2'b00, 1'b0};
      3'd2:    return {2'b01, 2'b00, 1'b0};
      3'd3:    return {2'b00, 2'b10, 1'b0};
      3'd4:    return {2'b00, 2'b01, 1'b0};
      3'd5:    return {2'b00, 2'b00, 1'b1};
      default: return {2'b00, 2'b00, 1'b0};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one tick period of 4 clocks; the expected state after the tick edge is queued first
  task automatic step(input logic [2:0] s);
    exp_q.push_back(s);
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic do_reset();
    ns_req = 1'b0; es_req = 1'b0; ped_req = 1'b0; tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_state", {29'd0, state_o}, 32'd0);
    chk("rst_lamps", {27'd0, ns_light, es_light, ped_walk}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // scoreboard monitor: one expected state per tick edge
  always @(posedge clk) begin
    if (tick && sb_en && !rst) begin
      #1;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL %s sb_empty: got state %0d, no expectation queued", tag, state_o);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_lamps = lamps(mon_exp);
        if (state_o !== mon_exp || {ns_light, es_light, ped_walk} !== mon_lamps) begin
          mismatched++;
          $display("FAIL %s: got state %0d lamps ns=%b es=%b walk=%b, expected state %0d ns=%b es=%b walk=%b",
                   tag, state_o, ns_light, es_light, ped_walk,
                   mon_exp, mon_lamps[4:3], mon_lamps[2:1], mon_lamps[0]);
        end
      end
    end
  end

  // lamp safety invariant, every clock
  always @(negedge clk) begin
    if (!rst) begin
      compared++;
      if ((ns_light != 2'b00 && es_light != 2'b00) ||
          (ped_walk && (ns_light != 2'b00 || es_light != 2'b00)) ||
          ns_light == 2'b11 || es_light == 2'b11 || state_o > 3'd5) begin
        mismatched++;
        $display("FAIL safety: state %0d ns=%b es=%b walk=%b", state_o, ns_light, es_light, ped_walk);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);

    tag = "c1_idle";
    do_reset();
    step(3'd1);
    repeat (50) step(3'd1);

    tag = "c2_es_req";
    do_reset();
    es_req = 1'b1;
    step(3'd1); step(3'd1); step(3'd2); step(3'd0); step(3'd3);
    es_req = 1'b0;
    step(3'd3); step(3'd3); step(3'd3);

    tag = "c3_both";
    do_reset();
    ns_req = 1'b1; es_req = 1'b1;
    step(3'd1); step(3'd1); step(3'd1); step(3'd1); step(3'd2); step(3'd0);
    step(3'd3); step(3'd3); step(3'd3); step(3'd3); step(3'd4); step(3'd0);
    step(3'd1); step(3'd1); step(3'd1); step(3'd1); step(3'd2); step(3'd0);
    step(3'd3);

    tag = "c4_ped";
    do_reset();
    step(3'd1);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    step(3'd1); step(3'd2); step(3'd0); step(3'd5); step(3'd5); step(3'd0);
    step(3'd3); step(3'd3);

    tag = "c5_midrst";
    do_reset();
    es_req = 1'b1;
    step(3'd1); step(3'd1); step(3'd2);
    chk("c5_in_yellow", {29'd0, state_o}, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("c5_async_state", {29'd0, state_o}, 32'd0);
    chk("c5_async_lamps", {27'd0, ns_light, es_light, ped_walk}, 32'd0);
    #1 rst = 1'b0;
    step(3'd1); step(3'd1); step(3'd2);

    tag = "c6_notick";
    do_reset();
    ns_req = 1'b1; es_req = 1'b1;
    step(3'd1);
    ped_req = 1'b1;
    repeat (200) @(negedge clk);
    chk("c6_hold_state", {29'd0, state_o}, 32'd1);
    chk("c6_hold_lamps", {27'd0, ns_light, es_light, ped_walk}, {27'd0, 5'b10000});
    ped_req = 1'b0;
    step(3'd1); step(3'd1); step(3'd1); step(3'd2);

    repeat (2) @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);

    tag = "random";
    sb_en = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      ns_req  = 1'($urandom_range(0, 1));
      es_req  = 1'($urandom_range(0, 1));
      ped_req = ($urandom_range(0, 15) == 0);
      tick    = ((i % 4) == 3);
    end
    @(negedge clk);
    tick = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
